decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the 5-stage MIPS pipeline. It sits between the IF/ID latch and the register bank / EX stage. It slices the instruction into register-bank read addresses and decodes the opcode into a control bundle. It detects load-use hazards and flushes, and registers operands, immediate and control into the ID/EX pipeline register.

## Interface
- SIZE, 32, data/instruction width
- NUM_REGISTERS, 32, register-file depth
- SIZE_REG_DIR, 5, register address width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- i_instr  in  SIZE  instruction from IF/ID latch
- i_pc_plus4  in  SIZE  PC+4 of i_instr
- i_valid  in  1  i_instr is a real instruction
- i_flush  in  1  branch/jump taken in EX; squash current ID instruction
- i_ex_mem_read  in  1  instruction now in EX is a load
- i_ex_wdir  in  SIZE_REG_DIR  destination register of the EX instruction
- o_dir_regA  out  SIZE_REG_DIR  rs = i_instr[25:21], combinational, to register bank
- o_dir_regB  out  SIZE_REG_DIR  rt = i_instr[20:16], combinational, to register bank
- i_reg_A, i_reg_B  in  SIZE  register-bank read data
- o_stall  out  1  combinational; IF and IF/ID hold
- o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_branch, o_bne  out  1 each  registered control
- o_alu_op  out  3  registered ALU operation
- o_rs, o_rt, o_wdir  out  SIZE_REG_DIR  registered source and final destination addresses
- o_reg_A, o_reg_B, o_imm, o_pc_plus4  out  SIZE  registered operands, extended immediate, PC+4
- o_illegal  out  1  registered one-cycle pulse on an undecodable valid opcode

## Operation
- Decoded opcodes:
  - R-type 000000
  - LW 100011, SW 101011
  - BEQ 000100, BNE 000101
  - ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, LUI 001111
- Immediate extension: ANDI/ORI zero-extend imm[15:0]; LUI yields {imm,16'h0}; all others sign-extend.
- o_wdir selection:
  - R-type: rd (instr[15:11])
  - I-type: rt
  - SW/BEQ/BNE: 0, with o_reg_write=0
- o_alu_op mapping: ADD=0 (LW/SW/ADDI), SUB=1 (BEQ/BNE), RTYPE=2 (EX decodes funct), AND=3, OR=4, SLT=5, LUI=6.
- rt counts as a source only for R-type, SW, BEQ and BNE; for LW and I-type ALU ops it is a destination.
- Load-use hazard: o_stall=1 when all of the following hold:
  - i_valid and !i_flush
  - i_ex_mem_read
  - i_ex_wdir != 0
  - i_ex_wdir == rs, or (i_ex_wdir == rt and rt is a source)
- Bubble: all control bits 0, o_valid=0, data fields don't-care (driven as captured).
- ID/EX capture at posedge, in priority order:
  - rst: all outputs 0
  - i_flush, or !i_valid: bubble
  - o_stall: bubble
  - illegal opcode: bubble, with o_illegal=1
  - otherwise: decoded bundle, o_valid=1
- Simultaneous flush and hazard: flush wins and o_stall=0, because the instruction is dead.

## Timing
- o_dir_regA/B are valid during the first half-cycle. The bank samples them on negedge. i_reg_A/B are captured at the next posedge.
- ID-to-EX latency is 1 cycle.
- o_stall lasts exactly 1 cycle per load-use pair. On the next cycle the load has left EX, so the condition clears.
- Reset value of every registered output is 0, including o_illegal.
- rst asserted mid-stall: outputs zero on that edge; o_stall is still computed combinationally from inputs.
- o_illegal is high for exactly the cycle following capture of an illegal valid instruction.

## Configuration
- DECODE_STAGE_JUMP_EN defined adds:
  - J 000010 and JAL 000011 decoded
  - extra outputs o_jump (1) and o_jump_target (SIZE) = {i_pc_plus4[31:28], instr[25:0], 2'b00}, registered
  - JAL: o_wdir=31, o_reg_write=1, o_imm=i_pc_plus4 (EX passes it through)
- DECODE_STAGE_JUMP_EN not defined:
  - J/JAL are illegal (bubble + o_illegal)
  - o_jump, o_jump_target ports absent

## Structure
- Shared package mips_pkg holds:
  - opcode constants
  - ALU-op constants
  - register-address width constant
  - the ID/EX control-bundle struct, shared with the EX stage
- One sub-module: control_decoder, a combinational opcode-to-control-bundle map. This file keeps the hazard logic and the ID/EX register.

## Test plan
- ADDI $5,$1,-3 (0x2025FFFD), i_reg_A=10, valid → next cycle o_imm=0xFFFFFFFD, o_wdir=5, o_alu_src=1, o_alu_op=0, o_reg_write=1, o_valid=1.
- EX has LW with i_ex_wdir=8, ID has ADD $9,$8,$2 → o_stall=1, next-cycle bubble (o_valid=0, o_reg_write=0). Same case with i_ex_wdir=0 → no stall.
- EX has LW to $8, ID has ADDI $8,$8,1 → stall (rs match). ID has LW $7,0($3) with EX writing $7 → no stall (rt is a destination).
- i_flush and hazard together → o_stall=0, bubble captured.
- Opcode 0x3F valid → bubble, o_illegal high one cycle. J 0x08000010 → jump fields when DECODE_STAGE_JUMP_EN is defined, else illegal.
- rst during a valid R-type → all outputs 0 the following cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Types and constants shared by the MIPS pipeline stages: opcodes, ALU ops and the ID/EX control bundle.
// Defining DECODE_STAGE_JUMP_EN adds the jump bit to the control bundle.
package mips_pkg;

  localparam int REG_DIR_W = 5;
  localparam int OPCODE_W  = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_RTYPE = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_SLT   = 3'd5,
    ALU_LUI   = 3'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_SIGN,
    IMM_ZERO,
    IMM_UPPER,
    IMM_PC
  } imm_sel_t;

  typedef enum logic [1:0] {
    WDIR_RD,
    WDIR_RT,
    WDIR_ZERO,
    WDIR_LINK
  } wdir_sel_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    bne;
`ifdef DECODE_STAGE_JUMP_EN
    logic    jump;
`endif
    alu_op_t alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // rt is read only by these formats; everywhere else it names the destination.
  function automatic logic is_rt_source(input logic [OPCODE_W-1:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
           (opcode == OP_BEQ)   || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode-to-control map for the decode stage.
// J/JAL are decoded only when DECODE_STAGE_JUMP_EN is defined; otherwise they are illegal.
module control_decoder
  import mips_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output imm_sel_t            imm_sel,
  output wdir_sel_t           wdir_sel,
  output logic                rt_is_src,
  output logic                illegal
);

  always_comb begin
    // NOTE: every output is defaulted before the case so no opcode path can infer a latch.
    ctrl     = CTRL_BUBBLE;
    imm_sel  = IMM_SIGN;
    wdir_sel = WDIR_ZERO;
    illegal  = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
        wdir_sel       = WDIR_RD;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        wdir_sel        = WDIR_RT;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.bne    = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        wdir_sel       = WDIR_RT;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_SLT;
        wdir_sel       = WDIR_RT;
      end
      OP_ANDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_AND;
        imm_sel        = IMM_ZERO;
        wdir_sel       = WDIR_RT;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OR;
        imm_sel        = IMM_ZERO;
        wdir_sel       = WDIR_RT;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_LUI;
        imm_sel        = IMM_UPPER;
        wdir_sel       = WDIR_RT;
      end
`ifdef DECODE_STAGE_JUMP_EN
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      // JAL links through the ALU: EX passes the immediate (PC+4) straight to $31.
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        imm_sel        = IMM_PC;
        wdir_sel       = WDIR_LINK;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign rt_is_src = is_rt_source(opcode);

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: register-bank addressing, opcode decode, load-use stall and the ID/EX pipeline register.
// Defining DECODE_STAGE_JUMP_EN adds J/JAL decode and the o_jump / o_jump_target outputs.
module decode_stage
  import mips_pkg::*;
#(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int SIZE_REG_DIR  = REG_DIR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIZE-1:0]         i_instr,
  input  logic [SIZE-1:0]         i_pc_plus4,
  input  logic                    i_valid,
  input  logic                    i_flush,
  input  logic                    i_ex_mem_read,
  input  logic [SIZE_REG_DIR-1:0] i_ex_wdir,
  output logic [SIZE_REG_DIR-1:0] o_dir_regA,
  output logic [SIZE_REG_DIR-1:0] o_dir_regB,
  input  logic [SIZE-1:0]         i_reg_A,
  input  logic [SIZE-1:0]         i_reg_B,
  output logic                    o_stall,
  output logic                    o_valid,
  output logic                    o_reg_write,
  output logic                    o_mem_read,
  output logic                    o_mem_write,
  output logic                    o_mem_to_reg,
  output logic                    o_alu_src,
  output logic                    o_branch,
  output logic                    o_bne,
  output logic [2:0]              o_alu_op,
  output logic [SIZE_REG_DIR-1:0] o_rs,
  output logic [SIZE_REG_DIR-1:0] o_rt,
  output logic [SIZE_REG_DIR-1:0] o_wdir,
  output logic [SIZE-1:0]         o_reg_A,
  output logic [SIZE-1:0]         o_reg_B,
  output logic [SIZE-1:0]         o_imm,
  output logic [SIZE-1:0]         o_pc_plus4,
  output logic                    o_illegal
`ifdef DECODE_STAGE_JUMP_EN
  ,
  output logic                    o_jump,
  output logic [SIZE-1:0]         o_jump_target
`endif
);

  localparam logic [SIZE_REG_DIR-1:0] LINK_REG = SIZE_REG_DIR'(NUM_REGISTERS - 1);

  logic [SIZE_REG_DIR-1:0] rs, rt, rd;
  logic [15:0]             imm16;

  assign rs    = i_instr[21 +: SIZE_REG_DIR];
  assign rt    = i_instr[16 +: SIZE_REG_DIR];
  assign rd    = i_instr[11 +: SIZE_REG_DIR];
  assign imm16 = i_instr[15:0];

  assign o_dir_regA = rs;
  assign o_dir_regB = rt;

  ctrl_t     dec_ctrl;
  imm_sel_t  imm_sel;
  wdir_sel_t wdir_sel;
  logic      rt_is_src;
  logic      dec_illegal;

  control_decoder u_control_decoder (
    .opcode    (i_instr[SIZE-1 -: OPCODE_W]),
    .ctrl      (dec_ctrl),
    .imm_sel   (imm_sel),
    .wdir_sel  (wdir_sel),
    .rt_is_src (rt_is_src),
    .illegal   (dec_illegal)
  );

  // A flushed instruction is dead, so it never holds up the front end.
  logic load_pending, hit_rs, hit_rt;

  assign load_pending = i_valid && !i_flush && i_ex_mem_read && (i_ex_wdir != '0);
  assign hit_rs       = (i_ex_wdir == rs);
  assign hit_rt       = (i_ex_wdir == rt) && rt_is_src;
  assign o_stall      = load_pending && (hit_rs || hit_rt);

  logic [SIZE-1:0]         imm_ext;
  logic [SIZE_REG_DIR-1:0] wdir;

  always_comb begin
    imm_ext = {{(SIZE-16){imm16[15]}}, imm16};
    case (imm_sel)
      IMM_ZERO:  imm_ext = {{(SIZE-16){1'b0}}, imm16};
      IMM_UPPER: imm_ext = {imm16, {(SIZE-16){1'b0}}};
      IMM_PC:    imm_ext = i_pc_plus4;
      default:   imm_ext = {{(SIZE-16){imm16[15]}}, imm16};
    endcase
  end

  always_comb begin
    wdir = '0;
    case (wdir_sel)
      WDIR_RD:   wdir = rd;
      WDIR_RT:   wdir = rt;
      WDIR_LINK: wdir = LINK_REG;
      default:   wdir = '0;
    endcase
  end

  logic  squash;
  ctrl_t ctrl_q;

  assign squash = !i_valid || i_flush || o_stall;

  // Data fields are captured on every non-reset edge; a bubble only clears the control side.
  // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= CTRL_BUBBLE;
      o_valid    <= 1'b0;
      o_illegal  <= 1'b0;
      o_rs       <= '0;
      o_rt       <= '0;
      o_wdir     <= '0;
      o_reg_A    <= '0;
      o_reg_B    <= '0;
      o_imm      <= '0;
      o_pc_plus4 <= '0;
`ifdef DECODE_STAGE_JUMP_EN
      o_jump_target <= '0;
`endif
    end else begin
      o_rs       <= rs;
      o_rt       <= rt;
      o_wdir     <= wdir;
      o_reg_A    <= i_reg_A;
      o_reg_B    <= i_reg_B;
      o_imm      <= imm_ext;
      o_pc_plus4 <= i_pc_plus4;
`ifdef DECODE_STAGE_JUMP_EN
      o_jump_target <= {i_pc_plus4[SIZE-1 -: 4], i_instr[25:0], 2'b00};
`endif
      if (squash) begin
        ctrl_q    <= CTRL_BUBBLE;
        o_valid   <= 1'b0;
        o_illegal <= 1'b0;
      end else if (dec_illegal) begin
        ctrl_q    <= CTRL_BUBBLE;
        o_valid   <= 1'b0;
        o_illegal <= 1'b1;
      end else begin
        ctrl_q    <= dec_ctrl;
        o_valid   <= 1'b1;
        o_illegal <= 1'b0;
      end
    end
  end

  assign o_reg_write  = ctrl_q.reg_write;
  assign o_mem_read   = ctrl_q.mem_read;
  assign o_mem_write  = ctrl_q.mem_write;
  assign o_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_alu_src    = ctrl_q.alu_src;
  assign o_branch     = ctrl_q.branch;
  assign o_bne        = ctrl_q.bne;
  assign o_alu_op     = ctrl_q.alu_op;
`ifdef DECODE_STAGE_JUMP_EN
  assign o_jump       = ctrl_q.jump;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases then random traffic against a table-driven reference.
// Builds with or without DECODE_STAGE_JUMP_EN.
module tb_decode_stage;

`ifdef DECODE_STAGE_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] i_instr, i_pc_plus4, i_reg_A, i_reg_B;
  logic        i_valid, i_flush, i_ex_mem_read;
  logic [4:0]  i_ex_wdir;
  logic [4:0]  o_dir_regA, o_dir_regB;
  logic        o_stall, o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
  logic        o_alu_src, o_branch, o_bne, o_illegal;
  logic [2:0]  o_alu_op;
  logic [4:0]  o_rs, o_rt, o_wdir;
  logic [31:0] o_reg_A, o_reg_B, o_imm, o_pc_plus4;
  logic        jump_obs;
  logic [31:0] jump_target_obs;
`ifdef DECODE_STAGE_JUMP_EN
  logic        o_jump;
  logic [31:0] o_jump_target;
  assign jump_obs        = o_jump;
  assign jump_target_obs = o_jump_target;
`else
  assign jump_obs        = 1'b0;
  assign jump_target_obs = 32'h0;
`endif

  decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .i_instr       (i_instr),
    .i_pc_plus4    (i_pc_plus4),
    .i_valid       (i_valid),
    .i_flush       (i_flush),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_wdir     (i_ex_wdir),
    .o_dir_regA    (o_dir_regA),
    .o_dir_regB    (o_dir_regB),
    .i_reg_A       (i_reg_A),
    .i_reg_B       (i_reg_B),
    .o_stall       (o_stall),
    .o_valid       (o_valid),
    .o_reg_write   (o_reg_write),
    .o_mem_read    (o_mem_read),
    .o_mem_write   (o_mem_write),
    .o_mem_to_reg  (o_mem_to_reg),
    .o_alu_src     (o_alu_src),
    .o_branch      (o_branch),
    .o_bne         (o_bne),
    .o_alu_op      (o_alu_op),
    .o_rs          (o_rs),
    .o_rt          (o_rt),
    .o_wdir        (o_wdir),
    .o_reg_A       (o_reg_A),
    .o_reg_B       (o_reg_B),
    .o_imm         (o_imm),
    .o_pc_plus4    (o_pc_plus4),
    .o_illegal     (o_illegal)
`ifdef DECODE_STAGE_JUMP_EN
    ,
    .o_jump        (o_jump),
    .o_jump_target (o_jump_target)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests    = 0;
  int failures = 0;
  logic seen_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          legal;
    bit          rw, mr, mw, m2r, src, br, bne, jmp;
    bit          rt_src;
    int          alu;
    logic [4:0]  wdir;
    logic [31:0] imm;
  } dec_t;

  // Reference decode straight from the instruction-set table.
  function automatic dec_t decode_ref(input logic [31:0] instr, input logic [31:0] pc);
    dec_t        d;
    logic [15:0] im;
    im       = instr[15:0];
    d        = '{default: 0};
    d.legal  = 1;
    d.imm    = {{16{im[15]}}, im};
    d.wdir   = instr[20:16];
    case (instr[31:26])
      6'h00: begin d.rw = 1; d.alu = 2; d.rt_src = 1; d.wdir = instr[15:11]; end
      6'h23: begin d.rw = 1; d.mr = 1; d.m2r = 1; d.src = 1; d.alu = 0; end
      6'h2b: begin d.mw = 1; d.src = 1; d.alu = 0; d.rt_src = 1; d.wdir = 0; end
      6'h04: begin d.br = 1; d.alu = 1; d.rt_src = 1; d.wdir = 0; end
      6'h05: begin d.br = 1; d.bne = 1; d.alu = 1; d.rt_src = 1; d.wdir = 0; end
      6'h08: begin d.rw = 1; d.src = 1; d.alu = 0; end
      6'h0a: begin d.rw = 1; d.src = 1; d.alu = 5; end
      6'h0c: begin d.rw = 1; d.src = 1; d.alu = 3; d.imm = {16'h0, im}; end
      6'h0d: begin d.rw = 1; d.src = 1; d.alu = 4; d.imm = {16'h0, im}; end
      6'h0f: begin d.rw = 1; d.src = 1; d.alu = 6; d.imm = {im, 16'h0}; end
      6'h02: begin
        if (JUMP_EN) begin d.jmp = 1; d.wdir = 0; end
        else d.legal = 0;
      end
      6'h03: begin
        if (JUMP_EN) begin d.jmp = 1; d.rw = 1; d.wdir = 31; d.imm = pc; end
        else d.legal = 0;
      end
      default: d.legal = 0;
    endcase
    return d;
  endfunction

  task automatic step(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic valid, input logic flush, input logic exmr,
                      input logic [4:0] exw, input logic r);
    dec_t d;
    logic stall_exp, live, ill;
    @(negedge clk);
    i_instr = instr; i_pc_plus4 = pc; i_reg_A = a; i_reg_B = b;
    i_valid = valid; i_flush = flush; i_ex_mem_read = exmr; i_ex_wdir = exw; rst = r;
    #1;
    d = decode_ref(instr, pc);
    stall_exp = valid && !flush && exmr && (exw != 0) &&
                ((exw == instr[25:21]) || (exw == instr[20:16] && d.rt_src));
    check("dir_regA", 32'(o_dir_regA), 32'(instr[25:21]));
    check("dir_regB", 32'(o_dir_regB), 32'(instr[20:16]));
    check("stall", 32'(o_stall), 32'(stall_exp));
    seen_stall = o_stall;
    @(posedge clk);
    #1;
    live = !r && valid && !flush && !stall_exp && d.legal;
    ill  = !r && valid && !flush && !stall_exp && !d.legal;
    check("valid", 32'(o_valid), 32'(live));
    check("illegal", 32'(o_illegal), 32'(ill));
    check("reg_write", 32'(o_reg_write), 32'(live && d.rw));
    check("mem_read", 32'(o_mem_read), 32'(live && d.mr));
    check("mem_write", 32'(o_mem_write), 32'(live && d.mw));
    check("mem_to_reg", 32'(o_mem_to_reg), 32'(live && d.m2r));
    check("alu_src", 32'(o_alu_src), 32'(live && d.src));
    check("branch", 32'(o_branch), 32'(live && d.br));
    check("bne", 32'(o_bne), 32'(live && d.bne));
    check("alu_op", 32'(o_alu_op), live ? 32'(d.alu) : 32'h0);
    if (JUMP_EN) check("jump", 32'(jump_obs), 32'(live && d.jmp));
    if (r) begin
      check("rst_rs", 32'(o_rs), 32'h0);
      check("rst_rt", 32'(o_rt), 32'h0);
      check("rst_wdir", 32'(o_wdir), 32'h0);
      check("rst_regA", o_reg_A, 32'h0);
      check("rst_regB", o_reg_B, 32'h0);
      check("rst_imm", o_imm, 32'h0);
      check("rst_pc", o_pc_plus4, 32'h0);
      if (JUMP_EN) check("rst_jtarget", jump_target_obs, 32'h0);
    end else if (live) begin
      check("rs", 32'(o_rs), 32'(instr[25:21]));
      check("rt", 32'(o_rt), 32'(instr[20:16]));
      check("wdir", 32'(o_wdir), 32'(d.wdir));
      check("regA", o_reg_A, a);
      check("regB", o_reg_B, b);
      check("imm", o_imm, d.imm);
      check("pc", o_pc_plus4, pc);
      if (JUMP_EN && d.jmp)
        check("jtarget", jump_target_obs, {pc[31:28], instr[25:0], 2'b00});
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08,
                             6'h0a, 6'h0c, 6'h0d, 6'h0f, 6'h02, 6'h03, 6'h3f};
    logic [5:0] op;
    op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)};
  endfunction

  initial begin
    rst = 1'b1; i_instr = '0; i_pc_plus4 = '0; i_reg_A = '0; i_reg_B = '0;
    i_valid = 1'b0; i_flush = 1'b0; i_ex_mem_read = 1'b0; i_ex_wdir = '0;

    step(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 1);
    step(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 1);

    // ADDI $5,$1,-3
    step(32'h2025FFFD, 32'h0000_0104, 32'd10, 32'd7, 1, 0, 0, 5'd0, 0);
    check("plan_addi_imm", o_imm, 32'hFFFF_FFFD);
    check("plan_addi_wdir", 32'(o_wdir), 32'd5);
    check("plan_addi_regA", o_reg_A, 32'd10);

    // ADD $9,$8,$2 behind LW $8, then the same with the load writing $0
    step(32'h01024820, 32'h0000_0108, 32'd1, 32'd2, 1, 0, 1, 5'd8, 0);
    check("plan_lu_stall", 32'(seen_stall), 32'd1);
    check("plan_lu_bubble", 32'(o_valid), 32'd0);
    step(32'h01024820, 32'h0000_0108, 32'd1, 32'd2, 1, 0, 1, 5'd0, 0);
    check("plan_wdir0_nostall", 32'(seen_stall), 32'd0);

    // rs match on ADDI $8,$8,1; rt-as-destination on LW $7,0($3)
    step(32'h21080001, 32'h0000_010C, 32'd3, 32'd4, 1, 0, 1, 5'd8, 0);
    check("plan_rs_stall", 32'(seen_stall), 32'd1);
    step(32'h8C670000, 32'h0000_0110, 32'd5, 32'd6, 1, 0, 1, 5'd7, 0);
    check("plan_rt_dest_nostall", 32'(seen_stall), 32'd0);

    // Flush wins over hazard
    step(32'h01024820, 32'h0000_0114, 32'd1, 32'd2, 1, 1, 1, 5'd8, 0);
    check("plan_flush_nostall", 32'(seen_stall), 32'd0);

    // Illegal opcode pulses once
    step(32'hFC000000, 32'h0000_0118, 32'd0, 32'd0, 1, 0, 0, 5'd0, 0);
    check("plan_illegal_hi", 32'(o_illegal), 32'd1);
    step(32'h2025FFFD, 32'h0000_011C, 32'd0, 32'd0, 1, 0, 0, 5'd0, 0);
    check("plan_illegal_lo", 32'(o_illegal), 32'd0);

    // J 0x08000010
    step(32'h08000010, 32'h4000_0004, 32'd0, 32'd0, 1, 0, 0, 5'd0, 0);
    if (JUMP_EN) check("plan_j_target", jump_target_obs, 32'h4000_0040);
    else         check("plan_j_illegal", 32'(o_illegal), 32'd1);

    // Reset over a valid R-type, and over a stalling pair
    step(32'h01024820, 32'h0000_0120, 32'd9, 32'd9, 1, 0, 0, 5'd0, 1);
    step(32'h01024820, 32'h0000_0124, 32'd9, 32'd9, 1, 0, 1, 5'd8, 1);
    check("plan_rst_stall", 32'(seen_stall), 32'd1);

    for (int n = 0; n < 600; n++) begin
      step(rand_instr(), $urandom, $urandom, $urandom,
           $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
